// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the multi-cycle CPU datapath
// and a variable-latency data memory. One access per accept: a legal request
// runs a req/ack handshake, while an illegal or misaligned one faults at once.
// Every output is driven straight from a register.

module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request legality: loads allow B/H/W/BU/HU, stores only B/H/W.
    function automatic logic req_legal_f(input logic is_wr, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_wr;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment check for the access size encoded in f3[1:0].
    function automatic logic aligned_f(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enable mask for the access.
    function automatic logic [3:0] lane_be_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes; the mask selects the live ones.
    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            2'b10:   d = wd;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] load_data_f(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (off)
            2'b00:   b = rw[7:0];
            2'b01:   b = rw[15:8];
            2'b10:   b = rw[23:16];
            2'b11:   b = rw[31:24];
            default: b = 8'd0;
        endcase
        h = off[1] ? rw[31:16] : rw[15:0];
        case (f3)
            3'b000:  d = {{24{b[7]}}, b};
            3'b001:  d = {{16{h[15]}}, h};
            3'b010:  d = rw;
            3'b100:  d = {24'd0, b};
            3'b101:  d = {16'd0, h};
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    state_t       state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic         is_load_r, is_load_s;
    logic [2:0]   funct3_r, funct3_s;
    logic [1:0]   off_r, off_s;
    logic         mem_req_r, mem_req_s;
    logic         mem_we_r, mem_we_s;
    logic [31:0]  mem_addr_r, mem_addr_s;
    logic [3:0]   mem_be_r, mem_be_s;
    logic [31:0]  mem_wdata_r, mem_wdata_s;
    logic [31:0]  rdata_r, rdata_s;
    logic         busy_r, busy_s;
    logic         done_r, done_s;
    logic         fault_r, fault_s;

    // Next-state and next-output decode for the IDLE/REQ/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        is_load_s   = is_load_r;
        funct3_s    = funct3_r;
        off_s       = off_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_be_s    = mem_be_r;
        mem_wdata_s = mem_wdata_r;
        rdata_s     = rdata_r;
        done_s      = 1'b0;
        fault_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_write || req_read) begin
                    // Write wins when both requests are raised together.
                    is_load_s = ~req_write;
                    funct3_s  = funct3;
                    off_s     = addr[1:0];
                    if (req_legal_f(req_write, funct3) && aligned_f(funct3, addr[1:0])) begin
                        state_s     = ST_REQ;
                        cnt_s       = {CW{1'b0}};
                        mem_req_s   = 1'b1;
                        mem_we_s    = req_write;
                        mem_addr_s  = {addr[31:2], 2'b00};
                        mem_be_s    = lane_be_f(funct3, addr[1:0]);
                        mem_wdata_s = req_write ? store_data_f(funct3, wdata) : 32'd0;
                    end else begin
                        // Bad request never touches memory.
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        fault_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (mem_ack) begin
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = 32'd0;
                    mem_be_s    = 4'b0000;
                    mem_wdata_s = 32'd0;
                    if (is_load_r) begin
                        rdata_s = load_data_f(funct3_r, off_r, mem_rdata);
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    // Memory never answered: give up, rdata keeps its old value.
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                    fault_s     = 1'b1;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = 32'd0;
                    mem_be_s    = 4'b0000;
                    mem_wdata_s = 32'd0;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s     = ST_IDLE;
                mem_req_s   = 1'b0;
                mem_we_s    = 1'b0;
                mem_addr_s  = 32'd0;
                mem_be_s    = 4'b0000;
                mem_wdata_s = 32'd0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_r       <= {CW{1'b0}};
            is_load_r   <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            is_load_r   <= is_load_s;
            funct3_r    <= funct3_s;
            off_r       <= off_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_be_r    <= mem_be_s;
            mem_wdata_r <= mem_wdata_s;
            rdata_r     <= rdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            fault_r     <= fault_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random load/store
// traffic, checked against a transaction-level reference model.

module tb_mem_access_unit;

    localparam int TO = 4;

    logic        CLK;
    logic        RSTn;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_rdata;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .req_read  (req_read),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    // Free-running clock, 10 ns period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case something hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        fault;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    // Reference: what one access should look like on the memory bus.
    function automatic exp_t model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rw);
        exp_t        e;
        int          sz;
        int          off;
        bit          legal;
        logic [31:0] mask;
        logic [31:0] v;
        off = int'(a[1:0]);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        e.fault = !legal || ((off % sz) != 0);
        e.addr  = a & ~32'd3;
        e.be    = 4'(((1 << sz) - 1) << off);
        if (!wr)          e.wd = 32'd0;
        else if (sz == 1) e.wd = 32'(wd[7:0]) * 32'h0101_0101;
        else if (sz == 2) e.wd = 32'(wd[15:0]) * 32'h0001_0001;
        else              e.wd = wd;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (rw >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        e.rd = v;
        return e;
    endfunction

    // One access from IDLE to back in IDLE; delay = wait cycles before ack
    // (delay >= TO means the memory never answers).
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rw, input int delay);
        exp_t e;
        int   reqs;
        int   exp_reqs;
        bit   exp_flt;
        e = model(wr, f3, a, wd, rw);
        req_read  = rd;
        req_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        mem_ack   = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        mem_ack   = 1'b0;
        if (e.fault) begin
            chk("flt_mem_req", 32'(mem_req), 32'd0);
            chk("flt_done", 32'(done), 32'd1);
            chk("flt_fault", 32'(fault), 32'd1);
            chk("flt_rdata", rdata, exp_rdata);
        end else begin
            reqs = 0;
            while (mem_req === 1'b1 && reqs < TO + 3) begin
                chk("req_we", 32'(mem_we), 32'(wr));
                chk("req_addr", mem_addr, e.addr);
                chk("req_be", 32'(mem_be), 32'(e.be));
                chk("req_wdata", mem_wdata, e.wd);
                chk("req_busy", 32'(busy), 32'd1);
                chk("req_done_lo", 32'(done), 32'd0);
                mem_ack   = (reqs == delay);
                mem_rdata = (reqs == delay) ? rw : $urandom;
                reqs++;
                @(posedge CLK); #1;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            exp_flt  = (delay >= TO);
            exp_reqs = exp_flt ? TO : delay + 1;
            chk("req_cycles", 32'(reqs), 32'(exp_reqs));
            chk("done", 32'(done), 32'd1);
            chk("fault", 32'(fault), 32'(exp_flt));
            chk("mem_req_drop", 32'(mem_req), 32'd0);
            if (!wr && !exp_flt) exp_rdata = e.rd;
            chk("rdata", rdata, exp_rdata);
        end
        @(posedge CLK); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
    endtask

    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          r_op;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_rdata = 32'd0;
        RSTn      = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // LB sign-extended from the top lane, zero-wait memory.
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
        chk("lb_value", rdata, 32'hFFFF_FF80);
        // SH upper half with 3 wait cycles.
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'd0, 3);
        // Misaligned LW.
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'h1111_2222, 0);
        chk("misal_rdata", rdata, 32'hFFFF_FF80);
        // LHU that never gets an ack.
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0, 32'h5555_AAAA, 100);
        // Both requests high: the store wins.
        do_access(1'b1, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_005A, 32'hFFFF_FFFF, 1);
        // Illegal store width (SBU code).
        do_access(1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678, 32'd0, 0);
        // LHU zero-extended from the upper half.
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'd0, 32'h8765_4321, 2);
        chk("lhu_value", rdata, 32'h0000_8765);

        // Reset in the middle of REQ aborts the access without a done.
        req_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0200;
        @(posedge CLK); #1;
        req_read = 1'b0;
        @(posedge CLK); #1;
        chk("abort_req_before", 32'(mem_req), 32'd1);
        RSTn = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        exp_rdata = 32'd0;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(posedge CLK); #1;
        chk("abort_no_done", 32'(done), 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 1);
        chk("lw_after_rst", rdata, 32'hCAFE_F00D);

        // Random traffic, mostly legal and aligned.
        for (int i = 0; i < 80; i++) begin
            r_op = $urandom_range(0, 2);
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_f3[1:0] == 2'd1) r_a[0] = 1'b0;
                if (r_f3[1:0] == 2'd2) r_a[1:0] = 2'b00;
            end
            do_access(r_op != 1, r_op != 0, r_f3, r_a, $urandom, $urandom,
                      $urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
